// File: rtl/cacheline_mem_adapter_if.sv
// Cache-side line request/response and banked memory burst signals of the line adapter.
// slave = adapter view; master = the caches and memory driving it.
interface cacheline_mem_adapter_if #(
    parameter int BEAT_W    = 64,
    parameter int BURST_LEN = 4
);
    localparam int LINE_W = BEAT_W * BURST_LEN;

    logic [31:0]       i_addr;
    logic              i_read;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic [31:0]       d_addr;
    logic              d_read;
    logic              d_write;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic [31:0]       bmem_addr;
    logic              bmem_read;
    logic              bmem_write;
    logic [BEAT_W-1:0] bmem_wdata;
    logic              bmem_ready;
    logic [31:0]       bmem_raddr;
    logic [BEAT_W-1:0] bmem_rdata;
    logic              bmem_rvalid;

    modport slave (
        input  i_addr, i_read, d_addr, d_read, d_write, d_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        output i_rdata, i_resp, d_rdata, d_resp,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata
    );

    modport master (
        output i_addr, i_read, d_addr, d_read, d_write, d_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        input  i_rdata, i_resp, d_rdata, d_resp,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata
    );
endinterface

// File: rtl/cacheline_mem_adapter.sv
// Arbitrates I/D-cache line requests onto a BURST_LEN x BEAT_W burst memory port.
// Define CACHE_ADAPTER_RR_ARB_EN for round-robin arbitration; default is D-cache priority.
module cacheline_mem_adapter #(
    parameter int BEAT_W    = 64,
    parameter int BURST_LEN = 4
) (
    input logic                    clk,
    input logic                    rst,
    cacheline_mem_adapter_if.slave bus
);
    localparam int            LINE_W    = BEAT_W * BURST_LEN;
    localparam int            CW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] LAST      = CW'(BURST_LEN - 1);
    localparam logic [31:0]   ADDR_MASK = ~32'(LINE_W / 8 - 1);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_BURST, RESP} state_e;

    state_e            state_q;
    logic [CW-1:0]     beat_cnt_q;
    logic [CW-1:0]     cnt_nxt;
    logic              grant_d_q;   // 1: D-cache owns the transaction
    logic [31:0]       addr_q;
    logic [LINE_W-1:0] line_q;
    logic [LINE_W-1:0] line_d;
    logic [31:0]       i_line;
    logic [31:0]       d_line;
    logic              d_req;
    logic              pick_d;
    logic              beat_ok;
    logic              req_live;

    assign i_line  = bus.i_addr & ADDR_MASK;
    assign d_line  = bus.d_addr & ADDR_MASK;
    assign d_req   = bus.d_read || bus.d_write;
    assign cnt_nxt = beat_cnt_q + CW'(1);
    assign beat_ok = bus.bmem_rvalid && (bus.bmem_raddr == addr_q);

`ifdef CACHE_ADAPTER_RR_ARB_EN
    logic prio_d_q;
    assign pick_d = d_req && (!bus.i_read || prio_d_q);
`else
    assign pick_d = d_req;
`endif

    // A withdrawn or retargeted read still drains, but gets no completion pulse.
    assign req_live = grant_d_q ? (bus.d_read && d_line == addr_q)
                                : (bus.i_read && i_line == addr_q);

    always_comb begin
        line_d = line_q;
        line_d[int'(beat_cnt_q)*BEAT_W +: BEAT_W] = bus.bmem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            beat_cnt_q     <= '0;
            grant_d_q      <= 1'b1;
            addr_q         <= '0;
            line_q         <= '0;
            bus.i_resp     <= 1'b0;
            bus.d_resp     <= 1'b0;
            bus.i_rdata    <= '0;
            bus.d_rdata    <= '0;
            bus.bmem_read  <= 1'b0;
            bus.bmem_write <= 1'b0;
            bus.bmem_addr  <= '0;
            bus.bmem_wdata <= '0;
`ifdef CACHE_ADAPTER_RR_ARB_EN
            prio_d_q       <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    beat_cnt_q <= '0;
                    if (d_req || bus.i_read) begin
                        grant_d_q     <= pick_d;
                        addr_q        <= pick_d ? d_line : i_line;
                        bus.bmem_addr <= pick_d ? d_line : i_line;
                        line_q        <= bus.d_wdata;
                        if (pick_d && bus.d_write) begin
                            state_q        <= WR_BURST;
                            bus.bmem_write <= 1'b1;
                            bus.bmem_wdata <= bus.d_wdata[BEAT_W-1:0];
                        end else begin
                            state_q       <= RD_REQ;
                            bus.bmem_read <= 1'b1;
                        end
                    end
                end
                RD_REQ: begin
                    if (bus.bmem_ready) begin
                        bus.bmem_read <= 1'b0;
                        beat_cnt_q    <= '0;
                        state_q       <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (beat_ok) begin
                        line_q     <= line_d;
                        beat_cnt_q <= cnt_nxt;
                        if (beat_cnt_q == LAST) begin
                            state_q <= RESP;
                            if (req_live && grant_d_q) begin
                                bus.d_resp  <= 1'b1;
                                bus.d_rdata <= line_d;
                            end else if (req_live) begin
                                bus.i_resp  <= 1'b1;
                                bus.i_rdata <= line_d;
                            end
                        end
                    end
                end
                WR_BURST: begin
                    if (bus.bmem_ready) begin
                        beat_cnt_q <= cnt_nxt;
                        if (beat_cnt_q == LAST) begin
                            state_q        <= RESP;
                            bus.bmem_write <= 1'b0;
                            bus.bmem_wdata <= '0;
                            bus.d_resp     <= 1'b1;
                        end else begin
                            bus.bmem_wdata <= line_q[int'(cnt_nxt)*BEAT_W +: BEAT_W];
                        end
                    end
                end
                RESP: begin
                    state_q       <= IDLE;
                    bus.i_resp    <= 1'b0;
                    bus.d_resp    <= 1'b0;
                    bus.i_rdata   <= '0;
                    bus.d_rdata   <= '0;
                    bus.bmem_addr <= '0;
`ifdef CACHE_ADAPTER_RR_ARB_EN
                    prio_d_q      <= !grant_d_q;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
